mpsoc_ahb3_wsram: RTL and testbench
===================================

MPSOC_AHB3_WSRAM -- requirements
Module: mpsoc_ahb3_wsram

Interface
REQ-001 SHALL have parameter XLEN, default 64, data bus width; legal values are 32 and 64.
REQ-002 SHALL have parameter PLEN, default 64, address bus width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of XLEN-bit words; power of two, at least 2.
REQ-004 SHALL have parameter WAIT_STATES, default 0, number of inserted wait cycles per transfer; legal range 0..7.
REQ-005 SHALL have port HCLK, input, 1 bit, single clock; all state changes on its rising edge.
REQ-006 SHALL have port HRESETn, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port HSEL, input, 1 bit, slave select.
REQ-008 SHALL have port HADDR, input, PLEN bits, byte address.
REQ-009 SHALL have port HWDATA, input, XLEN bits, write data, valid in the data phase.
REQ-010 SHALL have port HRDATA, output, XLEN bits, read data.
REQ-011 SHALL have port HWRITE, input, 1 bit, 1 = write.
REQ-012 SHALL have ports HSIZE (input, 3 bits), HBURST (input, 3 bits), HPROT (input, 4 bits) and HMASTLOCK (input, 1 bit); HBURST, HPROT and HMASTLOCK are accepted and have no effect on behaviour.
REQ-013 SHALL have port HTRANS, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-014 SHALL have port HREADY, input, 1 bit, bus-level ready.
REQ-015 SHALL have port HREADYOUT, output, 1 bit, slave ready.
REQ-016 SHALL have port HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-017 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1; on acceptance it SHALL register the address, HWRITE and HSIZE.
REQ-018 SHALL treat the following address phases as no transfer: IDLE, BUSY, or HSEL=0. It SHALL respond with HREADYOUT=1 and HRESP=0 and leave memory unchanged.
REQ-019 SHALL flag an accepted transfer as an error if any of the following holds:
- the word index HADDR[PLEN-1:log2(XLEN/8)] >= MEM_DEPTH;
- HSIZE > log2(XLEN/8);
- HADDR is not aligned to 2^HSIZE.
REQ-020 SHALL implement the FSM states IDLE, WAIT, ERR1 and ERR2, with these transitions on an accepted transfer:
- error -> ERR1;
- otherwise, if WAIT_STATES > 0 -> WAIT;
- otherwise -> IDLE, and the data phase completes in its first cycle.
REQ-021 In WAIT, SHALL drive HREADYOUT=0 and count down a 3-bit counter loaded with WAIT_STATES-1; when the counter reaches 0 the next cycle SHALL be the final data-phase cycle with HREADYOUT=1, and the FSM returns to IDLE or follows REQ-017.
REQ-022 SHALL give an error transfer exactly two data-phase cycles:
- ERR1: HREADYOUT=0, HRESP=1;
- ERR2: HREADYOUT=1, HRESP=1.
An address phase accepted during ERR2 SHALL be processed per REQ-017.
REQ-023 SHALL commit a write on the final data-phase cycle, i.e. the cycle with HREADYOUT=1.
REQ-024 SHALL write only the byte lanes selected by HSIZE and the address low bits, leaving the other bytes of the word unchanged.
REQ-025 SHALL never write memory on an error transfer.
REQ-026 SHALL present a read's word on HRDATA in every cycle where HREADYOUT=1 for that read; the transfer latency is WAIT_STATES+1 cycles from address-phase acceptance.
REQ-027 SHALL make a read whose address phase overlaps the final data phase of a write to the same word return the merged new bytes (write-to-read forwarding), with no added wait state.
REQ-028 SHALL drive HRDATA to all zeros during write data phases, error data phases and idle cycles.
REQ-029 SHALL insert no wait states for back-to-back NONSEQ/SEQ transfers with WAIT_STATES=0, i.e. one transfer per cycle.

Reset
REQ-030 While HRESETn=0, SHALL force the following, asynchronously: FSM=IDLE, wait counter=0, HREADYOUT=1, HRESP=0, HRDATA=0, pending-write registers cleared.
REQ-031 SHALL abandon any transfer in progress when reset asserts; a pending write SHALL NOT commit.
REQ-032 SHALL not reset memory contents.
REQ-033 SHALL accept an address phase in the first cycle after HRESETn deasserts.

Verification
REQ-034 With XLEN=64 and WAIT_STATES=0: write 64'h0123_4567_89AB_CDEF to 0x10, then immediately read 0x10 -> HRDATA=64'h0123_4567_89AB_CDEF in the next cycle, HREADYOUT stays 1.
REQ-035 With WAIT_STATES=3: read 0x08 -> HREADYOUT low for exactly 3 cycles, then high with data and HRESP=0.
REQ-036 Byte write of 8'hA5 (HSIZE=0) to 0x13 over a word holding all zeros -> a read of 0x10 returns 64'h0000_0000_A500_0000.
REQ-037 With MEM_DEPTH=256, write to 0x800 -> ERR1 then ERR2 (HREADYOUT 0 then 1, HRESP=1 for both); a later read of 0x000 is unchanged.
REQ-038 HSIZE=3 at address 0x04 -> ERROR response; HSIZE=2 at address 0x04 -> OKAY.
REQ-039 Assert HRESETn=0 in the middle of a WAIT_STATES=5 write -> HREADYOUT=1 and HRESP=0 immediately; a subsequent read shows the old data.

Source files
------------

// File: rtl/mpsoc_ahb3_wsram.sv
// AHB3-Lite single-port SRAM slave with a configurable number of wait states,
// byte-lane writes, write-to-read forwarding and a two-cycle ERROR response.
module mpsoc_ahb3_wsram #(
  parameter int XLEN        = 64,
  parameter int PLEN        = 64,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic [1:0]      dbg_state
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(MEM_DEPTH);
  localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic            pend_valid;
  logic            pend_write;
  logic [AW-1:0]   pend_idx;
  logic [OFF-1:0]  pend_off;
  logic [2:0]      pend_size;

  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic            accept;
  logic            misalign;
  logic            req_err;
  logic            commit;
  logic [AW-1:0]   addr_idx;
  logic [OFF-1:0]  addr_off;
  logic [NB-1:0]   pend_mask;
  logic [XLEN-1:0] rd_new;
  logic [XLEN-1:0] rd_pend;
  logic            unused_inputs;

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};
  assign dbg_state     = state;

  // Bytes of the word touched by a transfer: the 2^size block holding off.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [OFF-1:0] off);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++)
      m[i] = ((i >> size) == (int'(off) >> size));
    return m;
  endfunction

  // HREADYOUT is high only in IDLE and ERR2, the cycles that may end a data phase.
  assign accept   = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign addr_idx = HADDR[OFF+AW-1:OFF];
  assign addr_off = HADDR[OFF-1:0];

  always_comb begin
    misalign = 1'b0;
    for (int i = 0; i < OFF; i++)
      if ((i < int'(HSIZE)) && HADDR[i]) misalign = 1'b1;
  end

  assign req_err   = (|HADDR[PLEN-1:OFF+AW]) | (HSIZE > 3'(OFF)) | misalign;
  assign pend_mask = lane_mask(pend_size, pend_off);
  // A pending OKAY transfer sitting in IDLE is in its final data-phase cycle.
  assign commit    = pend_valid & pend_write & (state == S_IDLE);
  assign rd_pend   = mem[pend_idx];

  // Read word for a new address phase, merged with a write committing this cycle.
  always_comb begin
    rd_new = mem[addr_idx];
    for (int i = 0; i < NB; i++)
      if (commit && (pend_idx == addr_idx) && pend_mask[i])
        rd_new[8*i +: 8] = HWDATA[8*i +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (commit)
      for (int i = 0; i < NB; i++)
        if (pend_mask[i]) mem[pend_idx][8*i +: 8] <= HWDATA[8*i +: 8];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      HREADYOUT  <= 1'b1;
      HRESP      <= 1'b0;
      HRDATA     <= '0;
      pend_valid <= 1'b0;
      pend_write <= 1'b0;
      pend_idx   <= '0;
      pend_off   <= '0;
      pend_size  <= 3'd0;
    end else if (accept) begin
      HRDATA <= '0;
      if (req_err) begin
        state      <= S_ERR1;
        HREADYOUT  <= 1'b0;
        HRESP      <= 1'b1;
        pend_valid <= 1'b0;
      end else begin
        pend_valid <= 1'b1;
        pend_write <= HWRITE;
        pend_idx   <= addr_idx;
        pend_off   <= addr_off;
        pend_size  <= HSIZE;
        HRESP      <= 1'b0;
        if (WAIT_STATES > 0) begin
          state     <= S_WAIT;
          cnt       <= WS_LOAD;
          HREADYOUT <= 1'b0;
        end else begin
          state     <= S_IDLE;
          HREADYOUT <= 1'b1;
          if (!HWRITE) HRDATA <= rd_new;
        end
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRDATA    <= pend_write ? '0 : rd_pend;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          HREADYOUT  <= 1'b1;
          HRESP      <= 1'b0;
          HRDATA     <= '0;
          pend_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_ahb3_wsram.sv
// Self-checking bench for mpsoc_ahb3_wsram: three instances (0, 3 and 5 wait
// states) share one AHB master; a byte-level memory model supplies expectations.
module tb_mpsoc_ahb3_wsram;

  localparam int ND = 3;
  localparam int WS_TAB [ND] = '{0, 3, 5};

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  int          dsel = 0;

  logic [63:0] hrdata_a    [ND];
  logic        hreadyout_a [ND];
  logic        hresp_a     [ND];
  logic [1:0]  dbg_a       [ND];
  logic        hsel_a      [ND];

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] model_mem [ND][256];

  typedef struct {
    bit          nop;
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } tr_t;

  tr_t tr_q[$];

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    assign hsel_a[g] = HSEL && (dsel == g);
    mpsoc_ahb3_wsram #(
      .XLEN(64), .PLEN(64), .MEM_DEPTH(256), .WAIT_STATES(WS_TAB[g])
    ) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_a[g]), .HADDR(HADDR),
      .HWDATA(HWDATA), .HRDATA(hrdata_a[g]), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
      .HREADY(hreadyout_a[g]), .HREADYOUT(hreadyout_a[g]), .HRESP(hresp_a[g]),
      .dbg_state(dbg_a[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic bit model_err(input logic [63:0] a, input logic [2:0] s);
    return ((a / 8) >= 256) || (s > 3) || ((a % (64'd1 << s)) != 0);
  endfunction

  task automatic model_write(input int d, input logic [63:0] a, input logic [2:0] s,
                             input logic [63:0] data);
    for (int b = 0; b < (1 << s); b++) begin
      int lane;
      lane = int'((a + 64'(b)) % 8);
      model_mem[d][a / 8][lane*8 +: 8] = data[lane*8 +: 8];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_tr(input bit nop, input bit sel, input logic [1:0] trans, input bit write,
                        input logic [63:0] addr, input logic [2:0] size, input logic [63:0] data);
    tr_t t;
    t.nop = nop; t.sel = sel; t.trans = trans; t.write = write;
    t.addr = addr; t.size = size; t.data = data;
    t.burst = 3'($urandom_range(0, 7));
    t.prot  = 4'($urandom_range(0, 15));
    t.lock  = 1'($urandom_range(0, 1));
    tr_q.push_back(t);
  endtask

  task automatic wr(input logic [63:0] addr, input logic [2:0] size, input logic [63:0] data);
    add_tr(1'b0, 1'b1, 2'($urandom_range(2, 3)), 1'b1, addr, size, data);
  endtask

  task automatic rd(input logic [63:0] addr, input logic [2:0] size);
    add_tr(1'b0, 1'b1, 2'($urandom_range(2, 3)), 1'b0, addr, size, {$urandom, $urandom});
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd0;
    HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0;
  endtask

  // Pipelined master: address phase of the queue head overlaps the data phase
  // of the previous transfer; each data-phase cycle is checked against the model.
  task automatic run_transfers();
    tr_t         dp;
    bit          dp_valid = 1'b0;
    bit          rdy;
    bit          err;
    int          waits = 0;
    int          exp_waits;
    int          budget;
    logic [63:0] exp_d;
    budget = 50 + 12 * tr_q.size();
    while (tr_q.size() > 0 || dp_valid) begin
      if (tr_q.size() > 0) begin
        HSEL = tr_q[0].sel; HTRANS = tr_q[0].trans; HWRITE = tr_q[0].write;
        HADDR = tr_q[0].addr; HSIZE = tr_q[0].size; HBURST = tr_q[0].burst;
        HPROT = tr_q[0].prot; HMASTLOCK = tr_q[0].lock;
      end else begin
        drive_idle();
      end
      HWDATA = (dp_valid && dp.write) ? dp.data : {$urandom, $urandom};
      @(negedge HCLK);
      rdy = hreadyout_a[dsel];
      err = dp_valid && model_err(dp.addr, dp.size);
      if (!dp_valid) begin
        n_vec++;
        if (hreadyout_a[dsel] !== 1'b1) begin
          n_err++; $display("FAIL idle_hreadyout: got %b expected 1", hreadyout_a[dsel]);
        end
        n_vec++;
        if (hresp_a[dsel] !== 1'b0 || hrdata_a[dsel] !== 64'd0) begin
          n_err++; $display("FAIL idle_outputs: got resp %b rdata %h expected resp 0 rdata 0",
                            hresp_a[dsel], hrdata_a[dsel]);
        end
      end else if (!rdy) begin
        waits++;
        n_vec++;
        if (hresp_a[dsel] !== err) begin
          n_err++; $display("FAIL wait_resp addr %h: got %b expected %b", dp.addr, hresp_a[dsel], err);
        end
        if (dp.write || err) begin
          n_vec++;
          if (hrdata_a[dsel] !== 64'd0) begin
            n_err++; $display("FAIL wait_rdata addr %h: got %h expected 0", dp.addr, hrdata_a[dsel]);
          end
        end
      end else begin
        exp_d     = (!dp.write && !err) ? model_mem[dsel][dp.addr / 8] : 64'd0;
        exp_waits = err ? 1 : WS_TAB[dsel];
        n_vec++;
        if (hresp_a[dsel] !== err) begin
          n_err++; $display("FAIL final_resp addr %h: got %b expected %b", dp.addr, hresp_a[dsel], err);
        end
        n_vec++;
        if (hrdata_a[dsel] !== exp_d) begin
          n_err++; $display("FAIL final_rdata addr %h wr %0b: got %h expected %h",
                            dp.addr, dp.write, hrdata_a[dsel], exp_d);
        end
        n_vec++;
        if (waits != exp_waits) begin
          n_err++; $display("FAIL wait_count addr %h: got %0d expected %0d", dp.addr, waits, exp_waits);
        end
        if (dp.write && !err) model_write(dsel, dp.addr, dp.size, dp.data);
      end
      @(posedge HCLK); #1;
      if (rdy) begin
        waits    = 0;
        dp_valid = 1'b0;
        if (tr_q.size() > 0) begin
          dp       = tr_q.pop_front();
          dp_valid = !dp.nop;
        end
      end
      budget--;
      if (budget == 0) begin
        n_vec++; n_err++;
        $display("FAIL timeout: got no HREADYOUT within cycle budget, expected completion");
        tr_q.delete();
        dp_valid = 1'b0;
      end
    end
    drive_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    HWDATA  = '0;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    for (int d = 0; d < ND; d++) begin
      n_vec++;
      if (hreadyout_a[d] !== 1'b1 || hresp_a[d] !== 1'b0 || hrdata_a[d] !== 64'd0) begin
        n_err++; $display("FAIL reset_outputs dut%0d: got ready %b resp %b rdata %h expected 1 0 0",
                          d, hreadyout_a[d], hresp_a[d], hrdata_a[d]);
      end
    end
    HRESETn = 1'b1;
  endtask

  task automatic test_directed_ws0();
    dsel = 0;
    wr(64'h000, 3'd3, 64'h1111_2222_3333_4444);
    wr(64'h010, 3'd3, 64'h0123_4567_89AB_CDEF);
    rd(64'h010, 3'd3);
    wr(64'h010, 3'd3, 64'd0);
    wr(64'h013, 3'd0, 64'h0000_0000_A500_0000);
    rd(64'h010, 3'd3);
    wr(64'h800, 3'd3, 64'hDEAD_BEEF_DEAD_BEEF);
    rd(64'h000, 3'd3);
    rd(64'h004, 3'd3);
    rd(64'h004, 3'd2);
    wr(64'h004, 3'd2, 64'h5555_6666_0000_0000);
    rd(64'h000, 3'd3);
    run_transfers();
  endtask

  task automatic test_wait_states();
    dsel = 1;
    wr(64'h008, 3'd3, {$urandom, $urandom});
    rd(64'h008, 3'd3);
    wr(64'h008, 3'd1, {$urandom, $urandom});
    rd(64'h008, 3'd3);
    run_transfers();
  endtask

  task automatic test_random(input int d, input int n);
    dsel = d;
    for (int w = 0; w < 16; w++) wr(64'(w * 8), 3'd3, {$urandom, $urandom});
    for (int k = 0; k < n; k++) begin
      int          kind;
      logic [2:0]  s;
      logic [63:0] a;
      kind = $urandom_range(0, 9);
      s    = 3'($urandom_range(0, 3));
      a    = 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7) & ~((1 << s) - 1));
      case (kind)
        0: add_tr(1'b0, 1'b1, 2'd2, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 15) * 8 + 1),
                  3'($urandom_range(1, 3)), {$urandom, $urandom});
        1: add_tr(1'b0, 1'b1, 2'd2, 1'($urandom_range(0, 1)), a & ~64'h7,
                  3'($urandom_range(4, 7)), {$urandom, $urandom});
        2: add_tr(1'b0, 1'b1, 2'd3, 1'b1, 64'h800 + 64'($urandom_range(0, 255) * 8), 3'd3,
                  {$urandom, $urandom});
        3: begin
          if ($urandom_range(0, 1) == 0)
            add_tr(1'b1, 1'b0, 2'd2, 1'b1, a, s, {$urandom, $urandom});
          else
            add_tr(1'b1, 1'b1, 2'($urandom_range(0, 1)), 1'b1, a, s, {$urandom, $urandom});
        end
        4, 5, 6: wr(a, s, {$urandom, $urandom});
        default: rd(a, s);
      endcase
    end
    for (int w = 0; w < 16; w++) rd(64'(w * 8), 3'd3);
    run_transfers();
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] old_d;
    old_d = {$urandom, $urandom};
    dsel  = 2;
    wr(64'h020, 3'd3, old_d);
    run_transfers();
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HADDR = 64'h020; HSIZE = 3'd3;
    @(posedge HCLK); #1;
    drive_idle();
    HWDATA = ~old_d;
    repeat (2) @(posedge HCLK);
    #1;
    n_vec++;
    if (hreadyout_a[2] !== 1'b0) begin
      n_err++; $display("FAIL midwrite_wait: got ready %b expected 0", hreadyout_a[2]);
    end
    HRESETn = 1'b0;
    #1;
    n_vec++;
    if (hreadyout_a[2] !== 1'b1 || hresp_a[2] !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got ready %b resp %b expected 1 0", hreadyout_a[2], hresp_a[2]);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd(64'h020, 3'd3);
    run_transfers();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed_ws0();
    test_wait_states();
    test_random(0, 60);
    test_random(1, 30);
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
